// File: rtl/wb_regfile_if.sv
// W-stage commit bundle and decode read ports shared between the pipeline and wb_regfile.
// The master side is the pipeline; the slave side is the register file.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned AW     = 4
);
    logic [2:0]        W_stat;
    logic [3:0]        W_icode;
    logic [AW-1:0]     W_dstE;
    logic [AW-1:0]     W_dstM;
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;
    logic [AW-1:0]     d_srcA;
    logic [AW-1:0]     d_srcB;
    logic [DATA_W-1:0] d_rvalA;
    logic [DATA_W-1:0] d_rvalB;

    modport master (
        output W_stat,
        output W_icode,
        output W_dstE,
        output W_dstM,
        output W_valE,
        output W_valM,
        output d_srcA,
        output d_srcB,
        input  d_rvalA,
        input  d_rvalB
    );

    modport slave (
        input  W_stat,
        input  W_icode,
        input  W_dstE,
        input  W_dstM,
        input  W_valE,
        input  W_valM,
        input  d_srcA,
        input  d_srcB,
        output d_rvalA,
        output d_rvalB
    );
endinterface

// File: rtl/wb_regfile.sv
// Y86-64 write-back stage and architectural register file with sticky terminal status.
// Define WB_BYPASS_EN to forward same-cycle write data onto the decode read ports.
module wb_regfile #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NREGS    = 15,
    parameter int unsigned AW       = 4,
    parameter int unsigned RSP_IDX  = 4,
    parameter int unsigned RSP_INIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    wb_regfile_if.slave        bus,
    output logic               halted,
    output logic [2:0]         stat_out,
    output logic [31:0]        retired
);
    localparam int unsigned STAT_W = 3;
    localparam int unsigned CNT_W  = 32;

    localparam logic [STAT_W-1:0] STAT_AOK = STAT_W'(1);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [DATA_W-1:0] regs [NREGS];

    logic live_c;
    logic e_sel_c;
    logic m_sel_c;
    logic e_we_c;
    logic m_we_c;
    logic retire_c;
    logic fault_c;

    // Which write ports the instruction class uses.
    always_comb begin
        e_sel_c = 1'b0;
        m_sel_c = 1'b0;
        unique case (bus.W_icode)
            I_CMOV, I_IRMOV, I_OPQ, I_CALL, I_RET, I_PUSHQ: e_sel_c = 1'b1;
            I_MRMOV: m_sel_c = 1'b1;
            I_POPQ: begin
                e_sel_c = 1'b1;
                m_sel_c = 1'b1;
            end
            default: begin
                e_sel_c = 1'b0;
                m_sel_c = 1'b0;
            end
        endcase
    end

    // An instruction commits only while running and reporting AOK; out-of-range
    // destinations (including RNONE) silently drop the write.
    always_comb begin
        live_c   = !halted && (bus.W_stat == STAT_AOK);
        fault_c  = !halted && (bus.W_stat != STAT_AOK);
        e_we_c   = live_c && e_sel_c && (32'(bus.W_dstE) < NREGS);
        m_we_c   = live_c && m_sel_c && (32'(bus.W_dstM) < NREGS);
        retire_c = live_c && (bus.W_icode != I_NOP);
    end

    // Register state; M-port wins when both ports target the same index.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (rst) begin
                regs[i] <= (i == RSP_IDX) ? DATA_W'(RSP_INIT) : '0;
            end else if (m_we_c && (32'(bus.W_dstM) == i)) begin
                regs[i] <= bus.W_valM;
            end else if (e_we_c && (32'(bus.W_dstE) == i)) begin
                regs[i] <= bus.W_valE;
            end
        end
    end

    // Terminal status: first non-AOK instruction at write-back freezes the machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted   <= 1'b0;
            stat_out <= STAT_AOK;
        end else if (fault_c) begin
            halted   <= 1'b1;
            stat_out <= bus.W_stat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (retire_c) begin
            retired <= retired + CNT_W'(1);
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (32'(idx) == i) begin
                v = regs[i];
            end
        end
`ifdef WB_BYPASS_EN
        if (e_we_c && (bus.W_dstE == idx)) begin
            v = bus.W_valE;
        end
        if (m_we_c && (bus.W_dstM == idx)) begin
            v = bus.W_valM;
        end
`endif
        return v;
    endfunction

    // Zero-latency decode reads.
    always_comb begin
        bus.d_rvalA = read_port(bus.d_srcA);
        bus.d_rvalB = read_port(bus.d_srcB);
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset state, commit rules, status latch, counter wrap.
module tb_wb_regfile;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NREGS    = 15;
    localparam int unsigned AW       = 4;
    localparam int unsigned RSP_IDX  = 4;
    localparam int unsigned RSP_INIT = 32'h0000_7F00;

    logic        clk;
    logic        rst;
    logic        halted;
    logic [2:0]  stat_out;
    logic [31:0] retired;

    int n_checks;
    int n_fail;

    wb_regfile_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    wb_regfile #(
        .DATA_W  (DATA_W),
        .NREGS   (NREGS),
        .AW      (AW),
        .RSP_IDX (RSP_IDX),
        .RSP_INIT(RSP_INIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .halted  (halted),
        .stat_out(stat_out),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] stat, input logic [3:0] icode,
                         input logic [3:0] dst_e, input logic [3:0] dst_m,
                         input logic [63:0] val_e, input logic [63:0] val_m);
        bus.W_stat  = stat;
        bus.W_icode = icode;
        bus.W_dstE  = dst_e;
        bus.W_dstM  = dst_m;
        bus.W_valE  = val_e;
        bus.W_valM  = val_m;
    endtask

    task automatic bubble();
        drive(3'd1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_a(input logic [3:0] idx, input string tag, input logic [63:0] exp);
        bus.d_srcA = idx;
        #1;
        check(tag, bus.d_rvalA, exp);
    endtask

    task automatic read_b(input logic [3:0] idx, input string tag, input logic [63:0] exp);
        bus.d_srcB = idx;
        #1;
        check(tag, bus.d_rvalB, exp);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.d_srcA = 4'h0;
        bus.d_srcB = 4'h0;
        bubble();
        step();
        step();

        // Reset state
        for (int i = 0; i < 15; i++) begin
            read_a(4'(i), "reset_reg", (i == 4) ? 64'h7F00 : 64'h0);
        end
        read_a(4'hF, "reset_rnone", 64'h0);
        check("reset_halted", 64'(halted), 64'h0);
        check("reset_stat", 64'(stat_out), 64'h1);
        check("reset_retired", 64'(retired), 64'h0);

        // irmov with same-cycle read
        rst = 1'b0;
        drive(3'd1, 4'h3, 4'h2, 4'hF, 64'h1234, 64'h0);
        bus.d_srcA = 4'h2;
        #1;
`ifdef WB_BYPASS_EN
        check("irmov_same_cycle", bus.d_rvalA, 64'h1234);
`else
        check("irmov_same_cycle", bus.d_rvalA, 64'h0);
`endif
        step();
        bubble();
        read_a(4'h2, "irmov_reg2", 64'h1234);
        check("irmov_retired", 64'(retired), 64'h1);

        // popq %rsp: M-port wins
        drive(3'd1, 4'hB, 4'h4, 4'h4, 64'h100, 64'hBEEF);
        step();
        bubble();
        read_a(4'h4, "popq_rsp_same", 64'hBEEF);
        check("popq_retired", 64'(retired), 64'h2);

        // popq with distinct destinations
        drive(3'd1, 4'hB, 4'h4, 4'h3, 64'h100, 64'hBEEF);
        step();
        bubble();
        read_a(4'h4, "popq_rsp_e", 64'h100);
        read_b(4'h3, "popq_r3_m", 64'hBEEF);

        // nop does not retire
        step();
        check("nop_retired", 64'(retired), 64'h3);

        // rmmov uses no write port; RNONE dst is dropped
        drive(3'd1, 4'h4, 4'h8, 4'hF, 64'h99, 64'h0);
        step();
        bubble();
        read_a(4'h8, "rmmov_no_write", 64'h0);
        check("rmmov_retired", 64'(retired), 64'h4);

        // mrmov writes through M-port
        drive(3'd1, 4'h5, 4'hF, 4'h7, 64'h0, 64'h55);
        step();
        bubble();
        read_b(4'h7, "mrmov_r7", 64'h55);

        // Counter wrap
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        #1;
        check("wrap_preload", 64'(retired), 64'hFFFF_FFFF);
        drive(3'd1, 4'h6, 4'h6, 4'hF, 64'h9, 64'h0);
        step();
        bubble();
        check("wrap_retired", 64'(retired), 64'h0);
        read_a(4'h6, "opq_r6", 64'h9);

        // Reset beats a simultaneous opq
        rst = 1'b1;
        drive(3'd1, 4'h6, 4'h5, 4'hF, 64'h7, 64'h0);
        step();
        rst = 1'b0;
        bubble();
        read_a(4'h5, "rst_opq_r5", 64'h0);
        read_b(4'h6, "rst_r6", 64'h0);
        read_a(4'h4, "rst_rsp", 64'h7F00);
        check("rst_opq_halted", 64'(halted), 64'h0);
        check("rst_opq_retired", 64'(retired), 64'h0);

        // ADR fault at write-back
        drive(3'd1, 4'h3, 4'h1, 4'hF, 64'h11, 64'h0);
        step();
        drive(3'd3, 4'h5, 4'hF, 4'h1, 64'h0, 64'hDEAD);
        step();
        bubble();
        read_a(4'h1, "adr_r1_kept", 64'h11);
        check("adr_halted", 64'(halted), 64'h1);
        check("adr_stat", 64'(stat_out), 64'h3);
        check("adr_retired", 64'(retired), 64'h1);

        // Frozen after halt
        drive(3'd1, 4'h3, 4'h1, 4'hF, 64'h22, 64'h0);
        bus.d_srcB = 4'h1;
        #1;
        check("halt_no_bypass", bus.d_rvalB, 64'h11);
        step();
        drive(3'd2, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        step();
        bubble();
        read_a(4'h1, "halt_r1_frozen", 64'h11);
        check("halt_stat_sticky", 64'(stat_out), 64'h3);
        check("halt_retired_frozen", 64'(retired), 64'h1);
        check("halt_sticky", 64'(halted), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
